// File: rtl/issue_pkg.sv
// Shared issue-stage types for the generic instruction queue.
// Holds the physical register id width, the wakeup pid width and the
// queue entry layout used by the ALU, MEM, BR and MUL queue wrappers.
package issue_pkg;

  localparam int PREG_W     = 6;
  localparam int WAKE_PID_W = PREG_W;

  // One source operand: ready bit, producer register id, and whether the
  // operand waits on a producer at all (forward_en == 0 means already valid).
  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] pid;
    logic              forward_en;
  } iq_src_t;

  typedef struct packed {
    iq_src_t           src1;
    iq_src_t           src2;
    logic [PREG_W-1:0] dst;
    logic [3:0]        ctl;
    logic [5:0]        op;
    logic [31:0]       imm;
    logic [31:0]       pc;
  } iq_entry_t;

endpackage

// File: rtl/iq_oldest_select.sv
// Oldest-ready picker for the collapsing issue queue.
// Ports:
//   ready - one bit per slot, slot 0 is the oldest
//   grant - one-hot vector marking the lowest-index ready slot
//   found - high when any slot is ready
module iq_oldest_select #(
  parameter int N = 8
) (
  input  logic [N-1:0] ready,
  output logic [N-1:0] grant,
  output logic         found
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = ready & (~ready + N'(1));
  assign found = |ready;

endmodule

// File: rtl/iq_select_queue.sv
// Generic collapsing, age-ordered issue queue with wakeup and oldest-ready
// select. Shared storage/reader for all functional-unit queue wrappers.
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   flush                    - synchronous clear of every entry
//   write_valid/write_entry  - enqueue request from the issue stage
//   full                     - no free slot, registered
//   wake_valid/wake_pid      - WAKE_N wakeup broadcasts
//   read_valid/read_entry    - oldest ready entry offered to execute
//   read_ready               - execute accepts the offered entry
//   count                    - number of occupied slots
module iq_select_queue
  import issue_pkg::*;
#(
  parameter int QLEN   = 8,
  parameter int WAKE_N = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 write_valid,
  input  iq_entry_t                            write_entry,
  output logic                                 full,
  input  logic [WAKE_N-1:0]                    wake_valid,
  input  logic [WAKE_N-1:0][WAKE_PID_W-1:0]    wake_pid,
  output logic                                 read_valid,
  output iq_entry_t                            read_entry,
  input  logic                                 read_ready,
  output logic [$clog2(QLEN):0]                count
);

  localparam int IDX_W = $clog2(QLEN);
  localparam int CNT_W = IDX_W + 1;

  iq_entry_t         entry_q [QLEN];
  iq_entry_t         entry_d [QLEN];
  logic [QLEN-1:0]   valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [QLEN-1:0]   ready_vec;
  logic [QLEN-1:0]   grant;
  logic              found;
  logic [IDX_W-1:0]  sel_idx;
  logic              read_fire;
  logic              write_accept;
  logic [CNT_W-1:0]  write_pos;

  function automatic iq_src_t wake_src(
    input iq_src_t                              src,
    input logic [WAKE_N-1:0]                    wv,
    input logic [WAKE_N-1:0][WAKE_PID_W-1:0]    wp
  );
    iq_src_t r;
    r = src;
    for (int k = 0; k < WAKE_N; k++) begin
      if (!src.valid && wv[k] && (wp[k] == src.pid)) begin
        r.valid = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic iq_entry_t wake_entry(
    input iq_entry_t                            e,
    input logic [WAKE_N-1:0]                    wv,
    input logic [WAKE_N-1:0][WAKE_PID_W-1:0]    wp
  );
    iq_entry_t r;
    r      = e;
    r.src1 = wake_src(e.src1, wv, wp);
    r.src2 = wake_src(e.src2, wv, wp);
    return r;
  endfunction

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < QLEN; i++) begin
      ready_vec[i] = valid_q[i] & entry_q[i].src1.valid & entry_q[i].src2.valid;
    end
  end

  iq_oldest_select #(.N(QLEN)) u_select (
    .ready (ready_vec),
    .grant (grant),
    .found (found)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < QLEN; i++) begin
      if (grant[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Selection only ever moves to an older slot (entries never lose
  // readiness), so the offered entry stays put while execute stalls.
  assign read_valid   = found;
  assign read_entry   = entry_q[sel_idx];
  assign full         = (count_q == CNT_W'(QLEN));
  assign count        = count_q;
  assign read_fire    = found && read_ready;
  assign write_accept = write_valid && !full;
  // The new entry lands after the collapse caused by a same-cycle read.
  assign write_pos    = count_q - CNT_W'(read_fire);

  always_comb begin
    entry_d = entry_q;
    for (int i = 0; i < QLEN; i++) begin
      if (read_fire && (i >= int'(sel_idx)) && (i < QLEN - 1)) begin
        entry_d[i] = wake_entry(entry_q[i+1], wake_valid, wake_pid);
      end else begin
        entry_d[i] = wake_entry(entry_q[i], wake_valid, wake_pid);
      end
      if (write_accept && (i == int'(write_pos))) begin
        entry_d[i] = wake_entry(write_entry, wake_valid, wake_pid);
      end
    end

    count_d = count_q + CNT_W'(write_accept) - CNT_W'(read_fire);
    if (flush) begin
      count_d = '0;
    end

    // Occupancy is always contiguous from slot 0.
    valid_d = '0;
    for (int i = 0; i < QLEN; i++) begin
      valid_d[i] = (CNT_W'(i) < count_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      valid_q <= '0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

endmodule

// File: tb/tb_iq_select_queue.sv
// Self-checking bench for iq_select_queue: directed scenarios followed by
// randomized traffic, compared against a queue-based behavioural model.
module tb_iq_select_queue;
  import issue_pkg::*;

  localparam int QLEN   = 8;
  localparam int WAKE_N = 4;

  logic                                clk = 1'b0;
  logic                                reset;
  logic                                flush;
  logic                                write_valid;
  iq_entry_t                           write_entry;
  logic                                full;
  logic [WAKE_N-1:0]                   wake_valid;
  logic [WAKE_N-1:0][WAKE_PID_W-1:0]   wake_pid;
  logic                                read_valid;
  iq_entry_t                           read_entry;
  logic                                read_ready;
  logic [$clog2(QLEN):0]               count;

  always #5 clk = ~clk;

  iq_select_queue #(.QLEN(QLEN), .WAKE_N(WAKE_N)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .write_valid (write_valid),
    .write_entry (write_entry),
    .full        (full),
    .wake_valid  (wake_valid),
    .wake_pid    (wake_pid),
    .read_valid  (read_valid),
    .read_entry  (read_entry),
    .read_ready  (read_ready),
    .count       (count)
  );

  int        tests_run    = 0;
  int        tests_failed = 0;
  iq_entry_t mdl_q[$];
  iq_entry_t exp_q[$];
  logic      mon_en = 1'b0;
  logic      mdl_rv;
  iq_entry_t mdl_sel;
  int        mdl_count;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic iq_entry_t mk_entry(input logic [31:0] pc, input logic v1, input logic [5:0] p1,
                                         input logic v2, input logic [5:0] p2);
    iq_entry_t e;
    e                 = '0;
    e.pc              = pc;
    e.imm             = ~pc;
    e.op              = pc[7:2];
    e.dst             = pc[9:4];
    e.ctl             = pc[5:2];
    e.src1.valid      = v1;
    e.src1.pid        = p1;
    e.src1.forward_en = !v1;
    e.src2.valid      = v2;
    e.src2.pid        = p2;
    e.src2.forward_en = !v2;
    return e;
  endfunction

  function automatic iq_src_t mdl_wake(input iq_src_t s, input logic [WAKE_N-1:0] wv,
                                       input logic [WAKE_N-1:0][WAKE_PID_W-1:0] wp);
    iq_src_t r;
    r = s;
    for (int k = 0; k < WAKE_N; k++) begin
      if (wv[k] && wp[k] == s.pid) r.valid = 1'b1;
    end
    return r;
  endfunction

  // Rebuild the externally visible view of the model: occupancy and the
  // oldest entry whose two sources are both available.
  task automatic refresh_view();
    bool_found: begin end
    mdl_count = mdl_q.size();
    mdl_rv    = 1'b0;
    mdl_sel   = '0;
    for (int i = 0; i < mdl_q.size(); i++) begin
      if (!mdl_rv && mdl_q[i].src1.valid && mdl_q[i].src2.valid) begin
        mdl_rv  = 1'b1;
        mdl_sel = mdl_q[i];
      end
    end
  endtask

  task automatic model_step(input logic wv, input iq_entry_t we, input logic [WAKE_N-1:0] wkv,
                            input logic [WAKE_N-1:0][WAKE_PID_W-1:0] wkp, input logic rr, input logic fl);
    int        idx;
    logic      accept;
    iq_entry_t t;
    if (fl) begin
      mdl_q.delete();
    end else begin
      idx = -1;
      for (int i = 0; i < mdl_q.size(); i++) begin
        if (idx < 0 && mdl_q[i].src1.valid && mdl_q[i].src2.valid) idx = i;
      end
      accept = wv && (mdl_q.size() < QLEN);
      for (int i = 0; i < mdl_q.size(); i++) begin
        t      = mdl_q[i];
        t.src1 = mdl_wake(t.src1, wkv, wkp);
        t.src2 = mdl_wake(t.src2, wkv, wkp);
        mdl_q[i] = t;
      end
      if (rr && idx >= 0) mdl_q.delete(idx);
      if (accept) begin
        t      = we;
        t.src1 = mdl_wake(t.src1, wkv, wkp);
        t.src2 = mdl_wake(t.src2, wkv, wkp);
        mdl_q.push_back(t);
      end
    end
    refresh_view();
  endtask

  // Drive one cycle of inputs, predict any read handshake, then advance the
  // model past the clock edge.
  task automatic applyStimulus(input logic wv, input iq_entry_t we, input logic [WAKE_N-1:0] wkv,
                               input logic [WAKE_N-1:0][WAKE_PID_W-1:0] wkp, input logic rr, input logic fl);
    write_valid = wv;
    write_entry = we;
    wake_valid  = wkv;
    wake_pid    = wkp;
    read_ready  = rr;
    flush       = fl;
    if (rr && mdl_rv) exp_q.push_back(mdl_sel);
    @(posedge clk);
    #1;
    model_step(wv, we, wkv, wkp, rr, fl);
  endtask

  task automatic idle(input logic rr);
    applyStimulus(1'b0, '0, '0, '0, rr, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        checkOutput("count", count, mdl_count);
        checkOutput("full", full, mdl_count == QLEN);
        checkOutput("read_valid", read_valid, mdl_rv);
        if (mdl_rv) checkOutput("offered_entry", read_entry, mdl_sel);
        if (read_valid && read_ready) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_read: got pc %0h expected no read", read_entry.pc);
          end else begin
            checkOutput("read_entry", read_entry, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [WAKE_N-1:0][WAKE_PID_W-1:0] wkp;
    iq_entry_t e;
    logic      v1, v2;

    reset       = 1'b1;
    flush       = 1'b0;
    write_valid = 1'b0;
    write_entry = '0;
    wake_valid  = '0;
    wake_pid    = '0;
    read_ready  = 1'b0;
    #3;
    checkOutput("reset_count", count, 0);
    checkOutput("reset_full", full, 0);
    checkOutput("reset_read_valid", read_valid, 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    refresh_view();
    mon_en = 1'b1;

    // Fill to capacity, then try one more write.
    for (int i = 0; i < QLEN; i++) begin
      applyStimulus(1'b1, mk_entry(32'h100 + 32'(4*i), 1'b1, 6'd0, 1'b1, 6'd0), '0, '0, 1'b0, 1'b0);
      if (i == 0) checkOutput("first_write_count", count, 1);
    end
    checkOutput("full_after_8", full, 1);
    applyStimulus(1'b1, mk_entry(32'h120, 1'b1, 6'd0, 1'b1, 6'd0), '0, '0, 1'b0, 1'b0);
    checkOutput("count_after_9th", count, 8);

    // Read and write together while full: read wins, write is refused.
    applyStimulus(1'b1, mk_entry(32'h124, 1'b1, 6'd0, 1'b1, 6'd0), '0, '0, 1'b1, 1'b0);
    checkOutput("count_full_rw", count, 7);
    checkOutput("head_after_rw", read_entry.pc, 32'h104);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Wakeup one cycle after the write.
    applyStimulus(1'b1, mk_entry(32'h200, 1'b0, 6'd5, 1'b1, 6'd0), '0, '0, 1'b0, 1'b0);
    checkOutput("rv_before_wake", read_valid, 0);
    wkp    = '0;
    wkp[2] = 6'd5;
    applyStimulus(1'b0, '0, 4'b0100, wkp, 1'b0, 1'b0);
    checkOutput("rv_after_wake", read_valid, 1);
    checkOutput("pc_after_wake", read_entry.pc, 32'h200);
    idle(1'b1);

    // Wakeup on the same edge as the write.
    wkp    = '0;
    wkp[0] = 6'd9;
    applyStimulus(1'b1, mk_entry(32'h300, 1'b1, 6'd0, 1'b0, 6'd9), 4'b0001, wkp, 1'b0, 1'b0);
    checkOutput("rv_same_cycle_wake", read_valid, 1);
    checkOutput("pc_same_cycle_wake", read_entry.pc, 32'h300);
    idle(1'b1);

    // Younger ready entry is read around older blocked ones.
    applyStimulus(1'b1, mk_entry(32'h400, 1'b0, 6'd10, 1'b1, 6'd0), '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk_entry(32'h404, 1'b0, 6'd11, 1'b1, 6'd0), '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk_entry(32'h408, 1'b1, 6'd0, 1'b1, 6'd0), '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, mk_entry(32'h40C, 1'b1, 6'd0, 1'b1, 6'd0), '0, '0, 1'b0, 1'b0);
    checkOutput("skip_select_pc", read_entry.pc, 32'h408);
    idle(1'b1);
    checkOutput("after_skip_count", count, 3);
    checkOutput("after_skip_pc", read_entry.pc, 32'h40C);
    wkp    = '0;
    wkp[1] = 6'd10;
    applyStimulus(1'b0, '0, 4'b0010, wkp, 1'b0, 1'b0);
    checkOutput("older_wins_pc", read_entry.pc, 32'h400);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Flush beats a concurrent write.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, mk_entry(32'h500 + 32'(4*i), 1'b1, 6'd0, 1'b1, 6'd0), '0, '0, 1'b0, 1'b0);
    end
    checkOutput("count_before_flush", count, 5);
    applyStimulus(1'b1, mk_entry(32'h600, 1'b1, 6'd0, 1'b1, 6'd0), '0, '0, 1'b0, 1'b1);
    checkOutput("flush_count", count, 0);
    checkOutput("flush_read_valid", read_valid, 0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      v1 = ($urandom_range(0, 1) == 1);
      v2 = ($urandom_range(0, 1) == 1);
      e  = mk_entry(32'h1000 + 32'(4*n), v1, 6'($urandom_range(0, 15)), v2, 6'($urandom_range(0, 15)));
      e.imm = $urandom;
      for (int k = 0; k < WAKE_N; k++) wkp[k] = 6'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 9) < 6, e,
                    {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                     ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)},
                    wkp, ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 2));
    end
    idle(1'b0);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/iq_select_queue.md
IQ_SELECT_QUEUE -- requirements
Module: iq_select_queue

Interface
REQ-001 Parameter QLEN, default 8: number of entry slots; SHALL be a power of two ≥2.
REQ-002 Parameter WAKE_N, default 4: number of wakeup broadcast ports.
REQ-003 Port clk  in  1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  in  1: asynchronous, active-high reset.
REQ-005 Port flush  in  1: synchronous clear of all entries.
REQ-006 Port write_valid  in  1: the issue stage presents an entry this cycle.
REQ-007 Port write_entry  in  iq_entry_t: the entry to enqueue (src1/src2 valid, pid, forward_en, dst, ctl, op, imm, pc).
REQ-008 Port full  out  1: no free slot; issue stage holds its write while high.
REQ-009 Port wake_valid  in  WAKE_N: wakeup broadcast strobes.
REQ-010 Port wake_pid  in  WAKE_N×PREG_W: physical register ids now ready.
REQ-011 Port read_valid  out  1: a selected entry is offered to execute.
REQ-012 Port read_entry  out  iq_entry_t: the selected entry.
REQ-013 Port read_ready  in  1: execute accepts; read_valid&&read_ready is a read fire.
REQ-014 Port count  out  $clog2(QLEN)+1: occupied slots.

Function
REQ-015 Storage SHALL be a collapsing age-ordered array: slot 0 is oldest; occupied slots are contiguous from 0.
REQ-016 Entry ready SHALL equal valid && src1.valid && src2.valid.
REQ-017 read_valid SHALL be high iff any stored entry is ready; read_entry SHALL be the lowest-index ready slot. Both are combinational from registered state only (no write_entry bypass).
REQ-018 read_entry SHALL be held stable while read_valid && !read_ready, unless an older entry becomes ready through wakeup; in that case the older entry replaces it.
REQ-019 On a read fire, the selected slot SHALL be removed and every younger slot SHALL shift down by one at the same edge.
REQ-020 full SHALL equal (count == QLEN) from registered count; a write is accepted iff write_valid && !full, even when a read fire occurs in the same cycle.
REQ-021 An accepted write SHALL land in the first free slot after the same-cycle removal; count_next = count + write_accept − read_fire.
REQ-022 Wakeup: for each stored entry and each source with !valid, the source valid bit SHALL be set at the next edge if any wake_valid[k] is high with wake_pid[k] == src.pid.
REQ-023 The same wakeup match SHALL also be applied to write_entry sources on the writing edge, so no broadcast concurrent with the write is lost.
REQ-024 Latency: an entry written ready at edge N SHALL be offered at read_valid in cycle N+1; a wakeup presented in cycle N SHALL make the entry selectable in cycle N+1.
REQ-025 flush SHALL empty the queue at the next edge: count 0, all slots invalid. flush SHALL take priority over write, read and wakeup in that cycle.
REQ-026 Sources with forward_en == 0 arrive with valid == 1 and SHALL never be cleared.

Reset
REQ-027 While reset is high, all slot valid bits and count SHALL be 0, so read_valid is 0 and full is 0 asynchronously; slot payload need not be cleared.
REQ-028 After reset deasserts, the first write SHALL be accepted at the first rising edge.

Structure
REQ-029 iq_entry_t, PREG_W and the wake port width SHALL reside in issue_pkg; no new package SHALL be created.
REQ-030 Oldest-ready selection SHALL be a sub-module, iq_oldest_select: a QLEN-bit ready vector in, a one-hot grant and a found flag out.
REQ-031 This block SHALL be the single generic reader/storage shared by the ALU, MEM, BR and MUL queue wrappers.

Verification
REQ-032 Reset, then write 8 ready entries (pc 0x100–0x11C) with read_ready=0 → full=1 after the 8th edge; a 9th write is ignored and count stays 8.
REQ-033 Full queue, with read_ready=1 and write_valid=1 in the same cycle → the pc 0x100 entry is read, the write is rejected, count=7.
REQ-034 Write an entry with src1.pid=5 not ready, then assert wake_valid[2] with wake_pid[2]=5 one cycle later → read_valid rises the next cycle with that entry.
REQ-035 Write an entry with src2.pid=9 not ready in the same cycle as a wake of pid 9 → the entry is selectable the next cycle.
REQ-036 Slots 0 and 1 not ready and slot 2 ready → slot 2 is read; slots 3.. shift down; a later wake of slot 0 makes it selected before the others.
REQ-037 Queue holding 5 entries, assert flush together with write_valid → count=0 and read_valid=0 on the next cycle.
